// File: rtl/ov7670_pixel_packer.sv
// ov7670_pixel_packer
//
// Capture front-end between the OV7670 parallel camera bus and the frame
// buffer write port. The camera pclk/href/vsync/data lines are brought into
// the wclk domain through two-flop synchronisers. Byte pairs are assembled
// into RGB565 pixels. The 640x480 sensor stream is decimated down to a
// c_img_cols x c_img_rows image, and the block drives the write address,
// write data and write enable of frame buffer port A.
//
// Ports:
//   wclk        system clock, must be at least 3x the pclk frequency
//   rst         synchronous, active-high reset
//   enable      capture write enable; 0 freezes buffer contents
//   pclk        camera pixel clock, asynchronous to wclk
//   vsync       camera vertical sync, high between frames
//   href        camera line valid
//   data[7:0]   camera data byte
//   addr        frame buffer write address
//   dout[15:0]  RGB565 pixel {r[4:0], g[5:0], b[4:0]}
//   we          one-cycle write strobe
//   frame_done  one-cycle pulse at the end of each captured frame
//   busy        high while a frame is being captured (ACTIVE state)
//
// Build option:
//   OV_PACKER_SWAP_RB_EN  when defined, the 5-bit red and blue fields of dout
//                         are swapped ({b5, g6, r5}) for BGR byte order.

module ov7670_pixel_packer #(
  parameter int c_img_cols    = 80,
  parameter int c_img_rows    = 60,
  parameter int c_img_pxls    = c_img_cols*c_img_rows,
  parameter int c_nb_img_pxls = 13,
  parameter int c_dec_log2    = 3
) (
  input  logic                     wclk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic                     pclk,
  input  logic                     vsync,
  input  logic                     href,
  input  logic [7:0]               data,
  output logic [c_nb_img_pxls-1:0] addr,
  output logic [15:0]              dout,
  output logic                     we,
  output logic                     frame_done,
  output logic                     busy
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SYNC,
    ST_ACTIVE
  } state_t;

  localparam logic [9:0]               c_col_lim   = 10'(c_img_cols);
  localparam logic [8:0]               c_line_lim  = 9'(c_img_rows);
  localparam logic [c_nb_img_pxls-1:0] c_addr_last = c_nb_img_pxls'(c_img_pxls - 1);

  state_t state;

  logic [1:0] pclk_s;
  logic [1:0] href_s;
  logic [1:0] vsync_s;
  logic [7:0] data_s1;
  logic [7:0] data_s2;
  logic       pclk_d;
  logic       href_d;
  logic       vsync_d;

  logic [9:0]               col;
  logic [8:0]               line;
  logic                     phase;
  logic [7:0]               hi_byte;
  logic [c_nb_img_pxls-1:0] addr_cnt;
  logic                     kept_any;

  logic        pclk_rise;
  logic        href_fall;
  logic        vsync_rise;
  logic [9:0]  col_dec;
  logic [8:0]  line_dec;
  logic        keep;
  logic [15:0] pixel;
  logic [15:0] pix_out;

  // Two-flop synchronisers plus one extra stage on the control lines for
  // edge detection. Data follows the same delay as pclk, so it is stable
  // when the synchronised pclk edge is seen.
  always_ff @(posedge wclk) begin
    if (rst) begin
      pclk_s  <= '0;
      href_s  <= '0;
      vsync_s <= '0;
      data_s1 <= '0;
      data_s2 <= '0;
      pclk_d  <= 1'b0;
      href_d  <= 1'b0;
      vsync_d <= 1'b0;
    end else begin
      pclk_s  <= {pclk_s[0], pclk};
      href_s  <= {href_s[0], href};
      vsync_s <= {vsync_s[0], vsync};
      data_s1 <= data;
      data_s2 <= data_s1;
      pclk_d  <= pclk_s[1];
      href_d  <= href_s[1];
      vsync_d <= vsync_s[1];
    end
  end

  assign pclk_rise  = pclk_s[1] & ~pclk_d;
  assign href_fall  = href_d & ~href_s[1];
  assign vsync_rise = vsync_s[1] & ~vsync_d;

  // A pixel survives decimation only on the first column/line of each
  // decimation block and only inside the output image window.
  assign col_dec  = col >> c_dec_log2;
  assign line_dec = line >> c_dec_log2;
  assign keep     = (col[c_dec_log2-1:0] == '0) && (line[c_dec_log2-1:0] == '0) &&
                    (col_dec < c_col_lim) && (line_dec < c_line_lim);

  assign pixel = {hi_byte, data_s2};

`ifdef OV_PACKER_SWAP_RB_EN
  assign pix_out = {pixel[4:0], pixel[10:5], pixel[15:11]};
`else
  assign pix_out = pixel;
`endif

  // Capture FSM. col and line saturate so that an oversized frame can never
  // wrap back into the image window. href falling has priority over a byte
  // edge, and it drops any half-assembled pixel.
  always_ff @(posedge wclk) begin
    we         <= 1'b0;
    frame_done <= 1'b0;
    if (rst) begin
      state    <= ST_IDLE;
      addr     <= '0;
      dout     <= '0;
      busy     <= 1'b0;
      col      <= '0;
      line     <= '0;
      phase    <= 1'b0;
      hi_byte  <= '0;
      addr_cnt <= '0;
      kept_any <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (vsync_s[1]) begin
            state <= ST_SYNC;
          end
        end
        ST_SYNC: begin
          if (!vsync_s[1]) begin
            state    <= ST_ACTIVE;
            busy     <= 1'b1;
            col      <= '0;
            line     <= '0;
            phase    <= 1'b0;
            addr_cnt <= '0;
            addr     <= '0;
            kept_any <= 1'b0;
          end
        end
        ST_ACTIVE: begin
          if (vsync_rise) begin
            state      <= ST_SYNC;
            busy       <= 1'b0;
            frame_done <= kept_any;
          end else if (href_fall) begin
            if (line != '1) begin
              line <= line + 9'd1;
            end
            col   <= '0;
            phase <= 1'b0;
          end else if (pclk_rise && href_s[1]) begin
            if (!phase) begin
              hi_byte <= data_s2;
              phase   <= 1'b1;
            end else begin
              phase <= 1'b0;
              if (col != '1) begin
                col <= col + 10'd1;
              end
              // addr and dout track every kept pixel; enable only gates we,
              // so the address stays correct across a disabled stretch.
              if (keep) begin
                addr     <= addr_cnt;
                dout     <= pix_out;
                we       <= enable;
                kept_any <= 1'b1;
                if (addr_cnt != c_addr_last) begin
                  addr_cnt <= addr_cnt + 1'b1;
                end
              end
            end
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ov7670_pixel_packer.sv
// tb_ov7670_pixel_packer
//
// Directed bench for ov7670_pixel_packer. The DUT is built as a small
// 4x3 image with decimation by 2, so a nominal sensor frame is 8x6 pixels.
// Each sensor pixel carries {line, col} as its byte pair, which gives every
// output address a known pixel value.

module tb_ov7670_pixel_packer;

  localparam int COLS = 4;
  localparam int ROWS = 3;
  localparam int PXLS = COLS*ROWS;
  localparam int AW   = 4;
  localparam int DEC  = 1;

  logic          wclk = 1'b0;
  logic          rst;
  logic          enable;
  logic          pclk;
  logic          vsync;
  logic          href;
  logic [7:0]    data;
  logic [AW-1:0] addr;
  logic [15:0]   dout;
  logic          we;
  logic          frame_done;
  logic          busy;

  int n_checks = 0;
  int n_pass   = 0;

  logic [AW-1:0] wa_q[$];
  logic [15:0]   wd_q[$];
  int            fd_cnt  = 0;
  int            long_we = 0;
  int            overlap = 0;
  logic          we_last = 1'b0;

  always #5 wclk = ~wclk;

  ov7670_pixel_packer #(
    .c_img_cols   (COLS),
    .c_img_rows   (ROWS),
    .c_img_pxls   (PXLS),
    .c_nb_img_pxls(AW),
    .c_dec_log2   (DEC)
  ) dut (
    .wclk      (wclk),
    .rst       (rst),
    .enable    (enable),
    .pclk      (pclk),
    .vsync     (vsync),
    .href      (href),
    .data      (data),
    .addr      (addr),
    .dout      (dout),
    .we        (we),
    .frame_done(frame_done),
    .busy      (busy)
  );

  // Record every write and frame_done pulse, sampled on the falling edge.
  always @(negedge wclk) begin
    if (we) begin
      wa_q.push_back(addr);
      wd_q.push_back(dout);
      if (we_last) long_we++;
      if (frame_done) overlap++;
    end
    if (frame_done) fd_cnt++;
    we_last = we;
  end

  initial begin
    #400us;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [15:0] exp_pix(input logic [7:0] hi, input logic [7:0] lo);
    logic [15:0] p;
    p = {hi, lo};
`ifdef OV_PACKER_SWAP_RB_EN
    return {p[4:0], p[10:5], p[15:11]};
`else
    return p;
`endif
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // One camera pclk period: data/href change while pclk is low.
  task automatic applyStimulus(input logic h, input logic [7:0] d);
    href = h;
    data = d;
    #20 pclk = 1'b1;
    #20 pclk = 1'b0;
  endtask

  task automatic send_line(input int l, input int nbytes);
    for (int b = 0; b < nbytes; b++)
      applyStimulus(1'b1, (b % 2 == 0) ? 8'(l) : 8'(b / 2));
    repeat (4) applyStimulus(1'b0, 8'h00);
  endtask

  task automatic frame_start();
    vsync = 1'b1;
    repeat (4) applyStimulus(1'b0, 8'h00);
    vsync = 1'b0;
    repeat (4) applyStimulus(1'b0, 8'h00);
  endtask

  task automatic frame_end();
    vsync = 1'b1;
    repeat (4) applyStimulus(1'b0, 8'h00);
  endtask

  task automatic send_lines(input int l0, input int l1, input int w,
                            input int odd_line, input int dis_lo, input int dis_hi);
    for (int l = l0; l <= l1; l++) begin
      enable = !(l >= dis_lo && l <= dis_hi);
      send_line(l, (l == odd_line) ? 3 : 2*w);
    end
    enable = 1'b1;
  endtask

  // Compare the writes recorded since 'base' with the expected address
  // sequence, skipping the addresses in [skip_lo, skip_hi].
  task automatic check_frame(input string tag, input int base, input int fd_base,
                             input int skip_lo, input int skip_hi);
    int k;
    int exp_cnt;
    exp_cnt = 0;
    for (int a = 0; a < PXLS; a++)
      if (!(a >= skip_lo && a <= skip_hi)) exp_cnt++;
    checkOutput({tag, "_cnt"}, wa_q.size() - base, exp_cnt);
    checkOutput({tag, "_fd"}, fd_cnt - fd_base, 1);
    k = 0;
    for (int a = 0; a < PXLS; a++) begin
      if (!(a >= skip_lo && a <= skip_hi)) begin
        if (base + k < wa_q.size()) begin
          checkOutput($sformatf("%s_addr%0d", tag, a), wa_q[base+k], a);
          checkOutput($sformatf("%s_dout%0d", tag, a), wd_q[base+k],
                      exp_pix(8'(2*(a / COLS)), 8'(2*(a % COLS))));
        end
        k++;
      end
    end
  endtask

  initial begin
    int base;
    int fd_base;
    rst = 1'b1; enable = 1'b1; pclk = 1'b0; vsync = 1'b0; href = 1'b0; data = 8'h00;
    repeat (4) @(posedge wclk);
    #2;
    checkOutput("rst_addr", addr, 0);
    checkOutput("rst_dout", dout, 0);
    checkOutput("rst_we", we, 0);
    checkOutput("rst_fd", frame_done, 0);
    checkOutput("rst_busy", busy, 0);
    rst = 1'b0;

    // Nominal frame.
    $display("[TB] nominal frame");
    base = wa_q.size(); fd_base = fd_cnt;
    frame_start();
    checkOutput("nom_busy_active", busy, 1);
    send_lines(0, 5, 8, -1, -1, -1);
    frame_end();
    checkOutput("nom_busy_after", busy, 0);
    check_frame("nom", base, fd_base, -1, -1);

    // Reset in the middle of a frame.
    $display("[TB] reset mid-frame");
    frame_start();
    send_lines(0, 2, 8, -1, -1, -1);
    @(posedge wclk); #2 rst = 1'b1;
    repeat (3) @(posedge wclk);
    #2 rst = 1'b0;
    checkOutput("rstmid_busy", busy, 0);
    checkOutput("rstmid_addr", addr, 0);
    base = wa_q.size(); fd_base = fd_cnt;
    send_lines(3, 5, 8, -1, -1, -1);
    frame_end();
    checkOutput("rstmid_no_we", wa_q.size() - base, 0);
    checkOutput("rstmid_no_fd", fd_cnt - fd_base, 0);
    base = wa_q.size(); fd_base = fd_cnt;
    frame_start();
    send_lines(0, 5, 8, -1, -1, -1);
    frame_end();
    check_frame("rstnext", base, fd_base, -1, -1);

    // Writes disabled in the middle rows, then resumed.
    $display("[TB] enable gap");
    base = wa_q.size(); fd_base = fd_cnt;
    frame_start();
    send_lines(0, 5, 8, -1, 2, 3);
    frame_end();
    check_frame("engap", base, fd_base, 4, 7);

    // Writes disabled for the bottom rows; address still runs to the end.
    $display("[TB] enable off at frame tail");
    base = wa_q.size(); fd_base = fd_cnt;
    frame_start();
    send_lines(0, 5, 8, -1, 4, 5);
    frame_end();
    check_frame("entail", base, fd_base, 8, 11);
    checkOutput("entail_addr_out", addr, PXLS - 1);
    checkOutput("entail_dout_out", dout, exp_pix(8'd4, 8'd6));

    // A 3-byte line must not leak its odd byte into the next line.
    $display("[TB] odd byte line");
    base = wa_q.size(); fd_base = fd_cnt;
    frame_start();
    send_lines(0, 5, 8, 1, -1, -1);
    frame_end();
    check_frame("odd", base, fd_base, -1, -1);

    // Oversized frame: extra columns and lines are never written.
    $display("[TB] oversized frame");
    base = wa_q.size(); fd_base = fd_cnt;
    frame_start();
    send_lines(0, 8, 12, -1, -1, -1);
    frame_end();
    check_frame("big", base, fd_base, -1, -1);
    checkOutput("big_addr_out", addr, PXLS - 1);

    checkOutput("we_single_cycle", long_we, 0);
    checkOutput("we_fd_overlap", overlap, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
